// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and
// read/write polarity.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_lane_steer.sv
// Big-endian lane steering within one aligned 4-byte row. Lane i is byte
// row_base+i and lives in bits [31-8i -: 8] of the row word.
module mem_lane_steer
  import mem_pkg::*;
(
  input  logic [1:0]  type_data,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_we,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  always_comb begin
    byte_we = 4'b0000;
    wr_word = '0;
    rd_data = '0;
    case (type_data)
      BYTE: begin
        byte_we[addr_lo] = 1'b1;
        wr_word          = {4{wdata[7:0]}};
        rd_data          = {24'd0, rd_word[8*(3-addr_lo) +: 8]};
      end
      HALF: begin
        // addr_lo[0] is ignored: halfwords are forced onto even addresses
        byte_we = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
        rd_data = {16'd0, (addr_lo[1] ? rd_word[15:0] : rd_word[31:16])};
      end
      WORD: begin
        byte_we = 4'b1111;
        wr_word = wdata;
        rd_data = rd_word;
      end
      default: begin
        byte_we = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Stallable memory responder for the MOV/MOC handshake: captures a request,
// waits WAIT_STATES cycles, performs a big-endian access and holds MOC.
//
// Handshake: the initiator raises MOV with request fields and keeps MOV high
// until it sees MOC; fields are captured on the IDLE->BUSY edge only. MOC stays
// high while MOV is held and falls at the first edge that samples MOV low.
// Dropping MOV before MOC aborts the request without touching the array.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        ERR,
  output logic        BUSY,
  output state_e      state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [7:0] mem [0:DEPTH-1];

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               moc_nxt, err_nxt;
  logic [31:0]        dout_nxt;
  logic               capture, do_access;

  logic               req_rw;
  logic [1:0]         req_type;
  logic [ADDR_W-1:0]  req_addr;
  logic [31:0]        req_data;

  logic [ADDR_W-3:0]  row;
  logic [3:0]         byte_we;
  logic [31:0]        wr_word, rd_word, rd_data;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^Addr[31:ADDR_W];
  assign row            = req_addr[ADDR_W-1:2];
  assign rd_word        = {mem[{row, 2'd0}], mem[{row, 2'd1}],
                           mem[{row, 2'd2}], mem[{row, 2'd3}]};

  mem_lane_steer u_steer (
    .type_data (req_type),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_data),
    .rd_word   (rd_word),
    .byte_we   (byte_we),
    .wr_word   (wr_word),
    .rd_data   (rd_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    moc_nxt   = MOC;
    err_nxt   = ERR;
    dout_nxt  = DataOut;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MOV) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = CNT_W'(WAIT_STATES);
          capture   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!MOV) begin
          state_nxt = ST_IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          do_access = 1'b1;
          moc_nxt   = 1'b1;
          err_nxt   = (req_type == ILLEGAL);
          state_nxt = ST_DONE;
          if (req_rw == RW_READ && req_type != ILLEGAL) begin
            dout_nxt = rd_data;
          end
        end
      end
      ST_DONE: begin
        if (!MOV) begin
          state_nxt = ST_IDLE;
          moc_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      MOC     <= 1'b0;
      ERR     <= 1'b0;
      DataOut <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      MOC     <= moc_nxt;
      ERR     <= err_nxt;
      DataOut <= dout_nxt;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      req_rw   <= RW_READ;
      req_type <= 2'b00;
      req_addr <= '0;
      req_data <= '0;
    end else if (capture) begin
      req_rw   <= RW;
      req_type <= typeData;
      req_addr <= Addr[ADDR_W-1:0];
      req_data <= DataIn;
    end
  end

  // The array is never reset; the !CLR guard gives reset priority on the access edge.
  always_ff @(posedge CLK) begin
    if (!CLR && do_access && req_rw == RW_WRITE) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_we[i]) begin
          mem[{row, 2'(i)}] <= wr_word[8*(3-i) +: 8];
        end
      end
    end
  end

  assign BUSY      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule
